alu_control_sequencer: RTL and testbench
========================================

// Module: alu_control_sequencer
// PURPOSE
//  Hardware control unit for the datapath. It drives the cpu strobes that the bench hand-drives today.
//  Runs fetch (T0-T2), then executes R-format ALU instructions (T3-T5/T6) by decoding IR.
//  Sits beside cpu; its outputs connect one-to-one to the cpu enable/out/op_code ports.
// PARAMETERS
//  NREGS    16  number of GPRs; width of the gpr_in/gpr_out one-hot vectors
//  OPW      5   opcode width (IR[31:27])
// PORTS
//  clk        in   1     rising-edge clock
//  reset_n    in   1     async active-low reset
//  run        in   1     1 = keep fetching; sampled at IDLE and at end of each instruction
//  mem_ready  in   1     memory read data valid on Mdatain this cycle
//  ir         in   32    current IR contents (cpu IR register output)
//  gpr_in     out  16    one-hot R0..R15 enable (Rx_enable)
//  gpr_out    out  16    one-hot R0..R15 bus drive (Rxout)
//  pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_read, mdr_out, ir_in, y_in  out 1 each
//  zlo_in, zhi_in, zlo_out, zhi_out, lo_in, hi_in                          out 1 each
//  op_code    out  5     ALU operation; 0 outside T4
//  instr_done out  1     1-cycle pulse in the final T-state of each instruction
//  illegal    out  1     1-cycle pulse when the decoded opcode is unsupported
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; every output 0; takes effect mid-instruction, no completion.
//  Outputs are Moore decodes of state (plus mem_ready in T1). The datapath captures them at the next rising edge.
//  Fields: opc=ir[31:27], ra=ir[26:23] dest, rb=ir[22:19] src1, rc=ir[18:15] src2.
//  Ops: 00011 add, 00100 sub, 00101 and, 00110 or, 00111 shr, 01000 shra, 01001 shl,
//       01010 ror, 01011 rol  (3-reg); 10001 neg, 10010 not (2-reg, rc ignored);
//       01111 mul, 10000 div (ra ignored; result to HI/LO). All others are illegal.
//  States:
//   IDLE: all outputs 0. run=1 -> T0.
//   T0: pc_out, mar_in, inc_pc, zlo_in -> T1.
//   T1: mdr_read=1, mdr_in=1 every cycle. If mem_ready=0, stay in T1 (wait states are unbounded).
//       If mem_ready=1, also assert zlo_out and pc_in -> T2. PC loads exactly once per fetch.
//   T2: mdr_out, ir_in -> T3.
//   T3: ir is now valid; decode. If illegal: illegal=1, instr_done=1, all strobes 0 -> T0 if run, else IDLE.
//       Otherwise gpr_out[rb], y_in -> T4.
//   T4: op_code=opc; zlo_in=1; zhi_in=1 for mul/div only.
//       3-reg and mul/div: gpr_out[rc]=1. neg/not: no bus driver.
//       -> T5.
//   T5: zlo_out=1. Writes gpr_in[ra] for ALU ops, lo_in for mul/div.
//       ALU ops: instr_done=1 -> T0 if run, else IDLE.
//       mul/div: -> T6.
//   T6: zhi_out, hi_in, instr_done -> T0 if run, else IDLE.
//  At most one bus driver (gpr_out/pc_out/mdr_out/zlo_out/zhi_out) is asserted per cycle.
//  gpr_in and gpr_out are each one-hot or zero.
//  Latency: 3-reg/2-reg op = 6 cycles; mul/div = 7; each mem wait cycle adds 1.
//  run=0 mid-instruction does not abort; it is sampled only at instruction end.
//  ra=rb=rc allowed; R0 is a normal writable register.
// TESTING
//  1. Preload R2=0x12, R3=0x14, R1=0x18. ir fetch 0x28918000, mem_ready=1, run=1.
//     -> T3 gpr_out=0x0004; T4 gpr_out=0x0008, op_code=00101; T5 gpr_in=0x0002; R1=0x10.
//  2. Same as 1 with mem_ready=0 for 3 cycles in T1.
//     -> mdr_read held 4 cycles; pc_in exactly 1 cycle; instr_done 3 cycles later than in 1.
//  3. mul R3,R4 (opc 01111, R3=6, R4=7).
//     -> T4 zhi_in=zlo_in=1; T5 lo_in=1; T6 hi_in=1; LO=42, HI=0; 7-cycle instruction.
//  4. not R5,R6 (opc 10010).
//     -> T4 gpr_out=0 with op_code=10010; T5 gpr_in=0x0020.
//  5. ir opc 11111. -> illegal and instr_done pulse in T3, no gpr_in/lo_in/hi_in; next state T0.
//  6. reset_n low during T4 -> all outputs 0 immediately; IDLE; with run=1 after release, fetch restarts at T0.

Source files
------------

// File: rtl/alu_control_sequencer.sv
// Hardwired control unit: fetches (T0-T2), then sequences R-format ALU, NEG/NOT and MUL/DIV
// instructions decoded from IR. It drives the datapath enable/out/op_code strobes.
module alu_control_sequencer #(
  parameter int NREGS = 16,
  parameter int OPW   = 5
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_run,
  input  logic             i_mem_ready,
  input  logic [31:0]      i_ir,
  output logic [NREGS-1:0] o_gpr_in,
  output logic [NREGS-1:0] o_gpr_out,
  output logic             o_pc_out,
  output logic             o_pc_in,
  output logic             o_inc_pc,
  output logic             o_mar_in,
  output logic             o_mdr_in,
  output logic             o_mdr_read,
  output logic             o_mdr_out,
  output logic             o_ir_in,
  output logic             o_y_in,
  output logic             o_zlo_in,
  output logic             o_zhi_in,
  output logic             o_zlo_out,
  output logic             o_zhi_out,
  output logic             o_lo_in,
  output logic             o_hi_in,
  output logic [OPW-1:0]   o_op_code,
  output logic             o_instr_done,
  output logic             o_illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
  } state_t;

  localparam logic [OPW-1:0] OP_ADD = OPW'(3);
  localparam logic [OPW-1:0] OP_ROL = OPW'(11);
  localparam logic [OPW-1:0] OP_MUL = OPW'(15);
  localparam logic [OPW-1:0] OP_DIV = OPW'(16);
  localparam logic [OPW-1:0] OP_NEG = OPW'(17);
  localparam logic [OPW-1:0] OP_NOT = OPW'(18);

  state_t r_state;

  logic [OPW-1:0]   w_opc;
  logic [3:0]       w_ra;
  logic [3:0]       w_rb;
  logic [3:0]       w_rc;
  logic [NREGS-1:0] w_raOh;
  logic [NREGS-1:0] w_rbOh;
  logic [NREGS-1:0] w_rcOh;
  logic             w_isAlu3;
  logic             w_isAlu2;
  logic             w_isMulDiv;
  logic             w_isIllegal;
  logic             w_unusedIr;

  assign w_opc       = i_ir[31:32-OPW];
  assign w_ra        = i_ir[26:23];
  assign w_rb        = i_ir[22:19];
  assign w_rc        = i_ir[18:15];
  assign w_raOh      = NREGS'(1) << w_ra;
  assign w_rbOh      = NREGS'(1) << w_rb;
  assign w_rcOh      = NREGS'(1) << w_rc;
  assign w_isAlu3    = (w_opc >= OP_ADD) && (w_opc <= OP_ROL);
  assign w_isAlu2    = (w_opc == OP_NEG) || (w_opc == OP_NOT);
  assign w_isMulDiv  = (w_opc == OP_MUL) || (w_opc == OP_DIV);
  assign w_isIllegal = !(w_isAlu3 || w_isAlu2 || w_isMulDiv);
  assign w_unusedIr  = ^i_ir[14:0];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (i_run) r_state <= S_T0;
        S_T0:   r_state <= S_T1;
        S_T1:   if (i_mem_ready) r_state <= S_T2;
        S_T2:   r_state <= S_T3;
        S_T3: begin
          if (w_isIllegal) r_state <= i_run ? S_T0 : S_IDLE;
          else             r_state <= S_T4;
        end
        S_T4:   r_state <= S_T5;
        S_T5: begin
          if (w_isMulDiv) r_state <= S_T6;
          else            r_state <= i_run ? S_T0 : S_IDLE;
        end
        S_T6:   r_state <= i_run ? S_T0 : S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes are decoded from state so an async reset clears them in the same instant;
  // only T1 also looks at mem_ready so PC loads once, on the cycle the read completes.
  always_comb begin
    o_gpr_in     = '0;
    o_gpr_out    = '0;
    o_pc_out     = 1'b0;
    o_pc_in      = 1'b0;
    o_inc_pc     = 1'b0;
    o_mar_in     = 1'b0;
    o_mdr_in     = 1'b0;
    o_mdr_read   = 1'b0;
    o_mdr_out    = 1'b0;
    o_ir_in      = 1'b0;
    o_y_in       = 1'b0;
    o_zlo_in     = 1'b0;
    o_zhi_in     = 1'b0;
    o_zlo_out    = 1'b0;
    o_zhi_out    = 1'b0;
    o_lo_in      = 1'b0;
    o_hi_in      = 1'b0;
    o_op_code    = '0;
    o_instr_done = 1'b0;
    o_illegal    = 1'b0;
    case (r_state)
      S_T0: begin
        o_pc_out = 1'b1;
        o_mar_in = 1'b1;
        o_inc_pc = 1'b1;
        o_zlo_in = 1'b1;
      end
      S_T1: begin
        o_mdr_read = 1'b1;
        o_mdr_in   = 1'b1;
        if (i_mem_ready) begin
          o_zlo_out = 1'b1;
          o_pc_in   = 1'b1;
        end
      end
      S_T2: begin
        o_mdr_out = 1'b1;
        o_ir_in   = 1'b1;
      end
      S_T3: begin
        if (w_isIllegal) begin
          o_illegal    = 1'b1;
          o_instr_done = 1'b1;
        end else begin
          o_gpr_out = w_rbOh;
          o_y_in    = 1'b1;
        end
      end
      S_T4: begin
        o_op_code = w_opc;
        o_zlo_in  = 1'b1;
        o_zhi_in  = w_isMulDiv;
        if (w_isAlu3 || w_isMulDiv) o_gpr_out = w_rcOh;
      end
      S_T5: begin
        o_zlo_out = 1'b1;
        if (w_isMulDiv) begin
          o_lo_in = 1'b1;
        end else begin
          o_gpr_in     = w_raOh;
          o_instr_done = 1'b1;
        end
      end
      S_T6: begin
        o_zhi_out    = 1'b1;
        o_hi_in      = 1'b1;
        o_instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Directed bench for alu_control_sequencer: per-cycle expected strobe vectors are queued
// per instruction and compared against the DUT outputs one cycle at a time.
module tb_alu_control_sequencer;

  typedef logic [53:0] vec_t;
  typedef struct {
    vec_t  exp;
    logic  memReady;
    string tag;
  } step_t;

  localparam logic [14:0] S_PCOUT  = 15'h4000;
  localparam logic [14:0] S_PCIN   = 15'h2000;
  localparam logic [14:0] S_INCPC  = 15'h1000;
  localparam logic [14:0] S_MARIN  = 15'h0800;
  localparam logic [14:0] S_MDRIN  = 15'h0400;
  localparam logic [14:0] S_MDRRD  = 15'h0200;
  localparam logic [14:0] S_MDROUT = 15'h0100;
  localparam logic [14:0] S_IRIN   = 15'h0080;
  localparam logic [14:0] S_YIN    = 15'h0040;
  localparam logic [14:0] S_ZLOIN  = 15'h0020;
  localparam logic [14:0] S_ZHIIN  = 15'h0010;
  localparam logic [14:0] S_ZLOOUT = 15'h0008;
  localparam logic [14:0] S_ZHIOUT = 15'h0004;
  localparam logic [14:0] S_LOIN   = 15'h0002;
  localparam logic [14:0] S_HIIN   = 15'h0001;

  logic        clk;
  logic        i_reset_n;
  logic        i_run;
  logic        i_mem_ready;
  logic [31:0] i_ir;
  logic [15:0] gpr_in;
  logic [15:0] gpr_out;
  logic        pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_read, mdr_out, ir_in, y_in;
  logic        zlo_in, zhi_in, zlo_out, zhi_out, lo_in, hi_in;
  logic [4:0]  op_code;
  logic        instr_done;
  logic        illegal;
  vec_t        obs;

  step_t sb[$];
  int    nCompared   = 0;
  int    nMismatched = 0;

  alu_control_sequencer #(.NREGS(16), .OPW(5)) dut (
    .i_clk        (clk),
    .i_reset_n    (i_reset_n),
    .i_run        (i_run),
    .i_mem_ready  (i_mem_ready),
    .i_ir         (i_ir),
    .o_gpr_in     (gpr_in),
    .o_gpr_out    (gpr_out),
    .o_pc_out     (pc_out),
    .o_pc_in      (pc_in),
    .o_inc_pc     (inc_pc),
    .o_mar_in     (mar_in),
    .o_mdr_in     (mdr_in),
    .o_mdr_read   (mdr_read),
    .o_mdr_out    (mdr_out),
    .o_ir_in      (ir_in),
    .o_y_in       (y_in),
    .o_zlo_in     (zlo_in),
    .o_zhi_in     (zhi_in),
    .o_zlo_out    (zlo_out),
    .o_zhi_out    (zhi_out),
    .o_lo_in      (lo_in),
    .o_hi_in      (hi_in),
    .o_op_code    (op_code),
    .o_instr_done (instr_done),
    .o_illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {gpr_in, gpr_out, pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_read, mdr_out,
                ir_in, y_in, zlo_in, zhi_in, zlo_out, zhi_out, lo_in, hi_in,
                op_code, instr_done, illegal};

  function automatic vec_t mk(input logic [15:0] gi, input logic [15:0] go,
                              input logic [14:0] st, input logic [4:0] op,
                              input logic done, input logic ill);
    return {gi, go, st, op, done, ill};
  endfunction

  function automatic logic [15:0] oneHot(input logic [3:0] idx);
    return 16'(1) << idx;
  endfunction

  task automatic pushStep(input vec_t exp, input logic memReady, input string tag);
    step_t s;
    s.exp      = exp;
    s.memReady = memReady;
    s.tag      = tag;
    sb.push_back(s);
  endtask

  task automatic checkOutput(input string tag, input vec_t exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered with the DUT about to be (or already) in T0; run is held low until the
  // final T-state so a mid-instruction run=0 must not cut the instruction short.
  task automatic applyStimulus(input string name, input logic [31:0] ir, input int waits,
                               input logic runNext, input int abortAfter);
    logic [4:0] opc;
    logic       alu3, alu2, md, ill;
    step_t      s;
    int         n;
    opc  = ir[31:27];
    alu3 = (opc >= 5'd3) && (opc <= 5'd11);
    alu2 = (opc == 5'd17) || (opc == 5'd18);
    md   = (opc == 5'd15) || (opc == 5'd16);
    ill  = !(alu3 || alu2 || md);
    pushStep(mk('0, '0, S_PCOUT | S_MARIN | S_INCPC | S_ZLOIN, '0, 1'b0, 1'b0), 1'b0,
             {name, ".T0"});
    for (int w = 0; w < waits; w++)
      pushStep(mk('0, '0, S_MDRRD | S_MDRIN, '0, 1'b0, 1'b0), 1'b0,
               $sformatf("%s.T1w%0d", name, w));
    pushStep(mk('0, '0, S_MDRRD | S_MDRIN | S_ZLOOUT | S_PCIN, '0, 1'b0, 1'b0), 1'b1,
             {name, ".T1"});
    pushStep(mk('0, '0, S_MDROUT | S_IRIN, '0, 1'b0, 1'b0), 1'b0, {name, ".T2"});
    if (ill) begin
      pushStep(mk('0, '0, '0, '0, 1'b1, 1'b1), 1'b0, {name, ".T3"});
    end else begin
      pushStep(mk('0, oneHot(ir[22:19]), S_YIN, '0, 1'b0, 1'b0), 1'b0, {name, ".T3"});
      pushStep(mk('0, (alu3 || md) ? oneHot(ir[18:15]) : 16'h0,
                  S_ZLOIN | (md ? S_ZHIIN : 15'h0), opc, 1'b0, 1'b0), 1'b0, {name, ".T4"});
      if (md) begin
        pushStep(mk('0, '0, S_ZLOOUT | S_LOIN, '0, 1'b0, 1'b0), 1'b0, {name, ".T5"});
        pushStep(mk('0, '0, S_ZHIOUT | S_HIIN, '0, 1'b1, 1'b0), 1'b0, {name, ".T6"});
      end else begin
        pushStep(mk(oneHot(ir[26:23]), '0, S_ZLOOUT, '0, 1'b1, 1'b0), 1'b0, {name, ".T5"});
      end
    end
    n = 0;
    while (sb.size() > 0 && (abortAfter < 0 || n < abortAfter)) begin
      s = sb.pop_front();
      @(negedge clk);
      if (n == 0) i_ir = ir;
      i_mem_ready = s.memReady;
      i_run       = (sb.size() == 0) ? runNext : 1'b0;
      #1;
      checkOutput(s.tag, s.exp);
      n++;
    end
    sb.delete();
  endtask

  initial begin
    i_reset_n   = 1'b0;
    i_run       = 1'b0;
    i_mem_ready = 1'b0;
    i_ir        = '0;
    @(negedge clk);
    #1 checkOutput("reset", '0);
    i_reset_n = 1'b1;
    @(negedge clk);
    i_run = 1'b1;
    #1 checkOutput("idle", '0);

    applyStimulus("and",      32'h28918000, 0, 1'b1, -1);
    applyStimulus("andWait",  32'h28918000, 3, 1'b1, -1);
    applyStimulus("mul",      {5'b01111, 4'd0, 4'd3, 4'd4, 15'd0}, 0, 1'b1, -1);
    applyStimulus("div",      {5'b10000, 4'd9, 4'd15, 4'd0, 15'd0}, 1, 1'b1, -1);
    applyStimulus("not",      {5'b10010, 4'd5, 4'd6, 4'd0, 15'd0}, 0, 1'b1, -1);
    applyStimulus("illegal",  {5'b11111, 27'd0}, 0, 1'b1, -1);
    applyStimulus("illegal0", 32'h0000_0000, 0, 1'b1, -1);
    applyStimulus("addSame",  {5'b00011, 4'd0, 4'd0, 4'd0, 15'd0}, 2, 1'b0, -1);

    @(negedge clk);
    i_run = 1'b0;
    #1 checkOutput("idleHold", '0);
    @(negedge clk);
    i_run = 1'b1;
    #1 checkOutput("idleRestart", '0);

    applyStimulus("rol", {5'b01011, 4'd15, 4'd14, 4'd13, 15'h7fff}, 0, 1'b1, 4);
    @(negedge clk);
    #1 checkOutput("rol.T4", mk('0, oneHot(4'd13), S_ZLOIN, 5'b01011, 1'b0, 1'b0));
    i_reset_n = 1'b0;
    #1 checkOutput("resetMid", '0);
    @(negedge clk);
    i_reset_n = 1'b1;
    i_run     = 1'b1;
    #1 checkOutput("idleAfterReset", '0);

    applyStimulus("sub", {5'b00100, 4'd7, 4'd8, 4'd9, 15'd0}, 0, 1'b0, -1);
    @(negedge clk);
    #1 checkOutput("idleEnd", '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
